// File: rtl/parking_gate_ctrl_pkg.sv
// Shared definitions for the parking gate controller: FSM encoding,
// default timing constants and a saturating timer helper.
package parking_gate_ctrl_pkg;

  localparam int DEF_DEBOUNCE     = 4;
  localparam int DEF_OPEN_TIMEOUT = 1000;
  localparam int DEF_CLOSE_CYCLES = 50;
  localparam int TIMER_W          = 16;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_CHECK      = 3'd1,
    ST_OPEN       = 3'd2,
    ST_PASSING    = 3'd3,
    ST_CLOSE      = 3'd4,
    ST_WAIT_LEAVE = 3'd5
  } gate_state_e;

  // Increment that sticks at all-ones instead of wrapping to zero.
  function automatic logic [TIMER_W-1:0] sat_inc(input logic [TIMER_W-1:0] val);
    return (&val) ? val : val + 1'b1;
  endfunction

endpackage

// File: rtl/gate_debounce.sv
// Two-flop synchroniser followed by a stable-count debouncer for one raw
// loop sensor. The filtered level follows the synchronised input only after
// DEBOUNCE consecutive samples that differ from the current level.
module gate_debounce
  import parking_gate_ctrl_pkg::*;
#(
  parameter int DEBOUNCE = DEF_DEBOUNCE
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_level
);

  localparam int                CNT_W    = $clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE - 1);

  logic [1:0]       r_sync;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;

  // Synchronise, then accept a new level after a full run of equal samples.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values; blocking here would collapse the sync chain.
    if (reset) begin
      r_sync  <= '0;
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_raw};
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_level <= r_sync[1];
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/parking_gate_ctrl.sv
// Barrier controller for one lane of the car park. Filters both loop
// sensors, decides entry against vacancy, raises/lowers the barrier and
// reports one event per completed passage to the occupancy core.
module parking_gate_ctrl
  import parking_gate_ctrl_pkg::*;
#(
  parameter bit IS_EXIT      = 1'b0,
  parameter int DEBOUNCE     = DEF_DEBOUNCE,
  parameter int OPEN_TIMEOUT = DEF_OPEN_TIMEOUT,
  parameter int CLOSE_CYCLES = DEF_CLOSE_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       arrive_loop,
  input  logic       pass_loop,
  input  logic       uni_card,
  input  logic       uni_is_vacated_space,
  input  logic       is_vacated_space,
  output logic       barrier_open,
  output logic       car_event_n,
  output logic       is_uni_event,
  output logic       deny,
  output logic       timeout_err,
  output logic       tailgate_err,
  output logic [2:0] state
);

  localparam logic [TIMER_W-1:0] OPEN_LIM  = TIMER_W'(OPEN_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] CLOSE_LIM = TIMER_W'(CLOSE_CYCLES - 1);

  logic w_arrive, w_pass;
  logic r_arrive_d, r_pass_d;
  logic w_arrive_rise, w_pass_rise, w_pass_fall;
  logic w_grant;

  gate_state_e        r_state, w_state_nxt;
  logic [TIMER_W-1:0] r_timer, w_timer_nxt;
  logic               r_uni_lat, w_uni_lat_nxt;
  logic               r_rev, w_rev_nxt;

  logic r_barrier_open, w_barrier_open_nxt;
  logic r_car_event_n,  w_car_event_n_nxt;
  logic r_is_uni_event, w_is_uni_event_nxt;
  logic r_deny,         w_deny_nxt;
  logic r_timeout_err,  w_timeout_err_nxt;
  logic r_tailgate_err, w_tailgate_err_nxt;

  gate_debounce #(.DEBOUNCE(DEBOUNCE)) u_arrive_db (
    .clk     (clk),
    .reset   (reset),
    .i_raw   (arrive_loop),
    .o_level (w_arrive)
  );

  gate_debounce #(.DEBOUNCE(DEBOUNCE)) u_pass_db (
    .clk     (clk),
    .reset   (reset),
    .i_raw   (pass_loop),
    .o_level (w_pass)
  );

  assign w_arrive_rise = w_arrive & ~r_arrive_d;
  assign w_pass_rise   = w_pass   & ~r_pass_d;
  assign w_pass_fall   = ~w_pass  &  r_pass_d;
  assign w_grant       = IS_EXIT | (r_uni_lat ? uni_is_vacated_space : is_vacated_space);

  // Next-state, timer and registered-output decode.
  always_comb begin
    // NOTE: every signal driven here gets a default first; a path that
    // skips an assignment would otherwise infer a latch.
    w_state_nxt        = r_state;
    w_timer_nxt        = '0;
    w_uni_lat_nxt      = r_uni_lat;
    w_rev_nxt          = r_rev;
    w_car_event_n_nxt  = 1'b1;
    w_is_uni_event_nxt = r_is_uni_event;
    w_deny_nxt         = 1'b0;
    w_timeout_err_nxt  = 1'b0;
    w_tailgate_err_nxt = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_arrive_rise) begin
          w_uni_lat_nxt = uni_card;
          w_state_nxt   = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (w_grant) begin
          w_state_nxt = ST_OPEN;
        end else begin
          w_deny_nxt  = 1'b1;
          w_state_nxt = ST_WAIT_LEAVE;
        end
      end
      ST_WAIT_LEAVE: begin
        if (!w_arrive) w_state_nxt = ST_IDLE;
      end
      ST_OPEN: begin
        w_rev_nxt = 1'b0;
        if (w_pass) begin
          w_state_nxt = ST_PASSING;
        end else if (r_timer == OPEN_LIM) begin
          w_timeout_err_nxt = 1'b1;
          w_state_nxt       = ST_CLOSE;
        end else begin
          w_timer_nxt = sat_inc(r_timer);
        end
      end
      ST_PASSING: begin
        // A fresh arrival after the car reached the barrier marks a reversal.
        if (w_arrive_rise) w_rev_nxt = 1'b1;
        if (w_pass_fall) begin
          w_state_nxt = ST_CLOSE;
          if (!(w_arrive && (r_rev || w_arrive_rise))) begin
            w_car_event_n_nxt  = 1'b0;
            w_is_uni_event_nxt = r_uni_lat;
          end
        end
      end
      ST_CLOSE: begin
        if (w_pass_rise) w_tailgate_err_nxt = 1'b1;
        if (r_timer == CLOSE_LIM) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_timer_nxt = sat_inc(r_timer);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    w_barrier_open_nxt = (w_state_nxt == ST_OPEN) || (w_state_nxt == ST_PASSING);
  end

  // State, timer, edge history and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_timer        <= '0;
      r_uni_lat      <= 1'b0;
      r_rev          <= 1'b0;
      r_arrive_d     <= 1'b0;
      r_pass_d       <= 1'b0;
      r_barrier_open <= 1'b0;
      r_car_event_n  <= 1'b1;
      r_is_uni_event <= 1'b0;
      r_deny         <= 1'b0;
      r_timeout_err  <= 1'b0;
      r_tailgate_err <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_timer        <= w_timer_nxt;
      r_uni_lat      <= w_uni_lat_nxt;
      r_rev          <= w_rev_nxt;
      r_arrive_d     <= w_arrive;
      r_pass_d       <= w_pass;
      r_barrier_open <= w_barrier_open_nxt;
      r_car_event_n  <= w_car_event_n_nxt;
      r_is_uni_event <= w_is_uni_event_nxt;
      r_deny         <= w_deny_nxt;
      r_timeout_err  <= w_timeout_err_nxt;
      r_tailgate_err <= w_tailgate_err_nxt;
    end
  end

  assign barrier_open = r_barrier_open;
  assign car_event_n  = r_car_event_n;
  assign is_uni_event = r_is_uni_event;
  assign deny         = r_deny;
  assign timeout_err  = r_timeout_err;
  assign tailgate_err = r_tailgate_err;
  assign state        = r_state;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed bench for parking_gate_ctrl. Tick counts in comments are cycles
// after the raw sensor change: 2 sync + DEBOUNCE(4) filter + 1 edge detect
// puts the FSM in CHECK 7 cycles after a raw arrival.
module tb_parking_gate_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       arrive, pass, uni_card, uni_vac, vac;
  logic       bo, ev_n, is_uni, deny, tmo, tg;
  logic [2:0] st;

  logic       x_arrive, x_pass, x_uni_card, x_uni_vac, x_vac;
  logic       x_bo, x_ev_n, x_is_uni, x_deny, x_tmo, x_tg;
  logic [2:0] x_st;

  parking_gate_ctrl #(
    .IS_EXIT(1'b0), .DEBOUNCE(4), .OPEN_TIMEOUT(20), .CLOSE_CYCLES(50)
  ) dut (
    .clk(clk), .reset(reset), .arrive_loop(arrive), .pass_loop(pass),
    .uni_card(uni_card), .uni_is_vacated_space(uni_vac), .is_vacated_space(vac),
    .barrier_open(bo), .car_event_n(ev_n), .is_uni_event(is_uni), .deny(deny),
    .timeout_err(tmo), .tailgate_err(tg), .state(st)
  );

  parking_gate_ctrl #(.IS_EXIT(1'b1)) dut_x (
    .clk(clk), .reset(reset), .arrive_loop(x_arrive), .pass_loop(x_pass),
    .uni_card(x_uni_card), .uni_is_vacated_space(x_uni_vac), .is_vacated_space(x_vac),
    .barrier_open(x_bo), .car_event_n(x_ev_n), .is_uni_event(x_is_uni), .deny(x_deny),
    .timeout_err(x_tmo), .tailgate_err(x_tg), .state(x_st)
  );

  int n_cmp = 0;
  int n_mis = 0;

  // Pulse / level-cycle tallies, sampled mid-cycle.
  int ev_cnt = 0, deny_cnt = 0, tmo_cnt = 0, tg_cnt = 0, bo_cnt = 0, xev_cnt = 0;
  always @(negedge clk) begin
    if (!ev_n)  ev_cnt   <= ev_cnt + 1;
    if (deny)   deny_cnt <= deny_cnt + 1;
    if (tmo)    tmo_cnt  <= tmo_cnt + 1;
    if (tg)     tg_cnt   <= tg_cnt + 1;
    if (bo)     bo_cnt   <= bo_cnt + 1;
    if (!x_ev_n) xev_cnt <= xev_cnt + 1;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int s_ev, s_deny, s_tmo, s_tg, s_bo, s_xev, bad;

  initial begin
    reset = 1'b1;
    {arrive, pass, uni_card, uni_vac, vac} = '0;
    {x_arrive, x_pass, x_uni_card, x_uni_vac, x_vac} = '0;
    adv(3);
    check("rst_state", st, 0);
    check("rst_barrier", bo, 0);
    check("rst_event_n", ev_n, 1);
    check("rst_is_uni", is_uni, 0);
    check("rst_deny", deny, 0);
    check("rst_timeout", tmo, 0);
    check("rst_tailgate", tg, 0);
    check("rst_x_state", x_st, 0);
    reset = 1'b0;
    adv(2);

    // Entry, other class, space free.
    s_ev = ev_cnt; s_bo = bo_cnt;
    arrive = 1'b1; vac = 1'b1;
    adv(6);  check("t1_idle_before_edge", st, 0);
    adv(1);  check("t1_check", st, 1);
    check("t1_bo_in_check", bo, 0);
    adv(1);  check("t1_open", st, 2);
    check("t1_bo_open", bo, 1);
    adv(2);  arrive = 1'b0; pass = 1'b1;            // tick 10
    adv(7);  check("t1_passing", st, 3);           // tick 17
    check("t1_bo_passing", bo, 1);
    adv(13); pass = 1'b0;                           // tick 30
    adv(6);  check("t1_still_passing", st, 3);     // tick 36
    check("t1_no_event_yet", ev_n, 1);
    adv(1);  check("t1_close", st, 4);             // tick 37
    check("t1_event_low", ev_n, 0);
    check("t1_event_class", is_uni, 0);
    check("t1_bo_dropped", bo, 0);
    adv(1);  check("t1_event_one_cycle", ev_n, 1);
    check("t1_bo_cycles", bo_cnt - s_bo, 29);
    adv(48); check("t1_close_last", st, 4);        // tick 86
    adv(1);  check("t1_idle_after_close", st, 0);  // tick 87
    check("t1_event_count", ev_cnt - s_ev, 1);

    // Entry refused: university card, no university space.
    s_ev = ev_cnt; s_deny = deny_cnt; s_bo = bo_cnt;
    arrive = 1'b1; uni_card = 1'b1; uni_vac = 1'b0; vac = 1'b1;
    adv(7);  check("t2_check", st, 1);
    adv(1);  check("t2_wait_leave", st, 5);        // tick 8
    check("t2_deny_pulse", deny, 1);
    adv(1);  check("t2_deny_one_cycle", deny, 0);
    adv(6);  arrive = 1'b0;                          // tick 15
    adv(6);  check("t2_still_waiting", st, 5);     // tick 21
    adv(1);  check("t2_idle", st, 0);              // tick 22
    check("t2_deny_count", deny_cnt - s_deny, 1);
    check("t2_no_event", ev_cnt - s_ev, 0);
    check("t2_bo_never", bo_cnt - s_bo, 0);
    uni_card = 1'b0;

    // Open timeout, tailgate in CLOSE, arrival in CLOSE ignored.
    s_ev = ev_cnt; s_tmo = tmo_cnt; s_tg = tg_cnt;
    arrive = 1'b1; vac = 1'b1;
    adv(8);  check("t3_open", st, 2);
    adv(2);  arrive = 1'b0;                          // tick 10
    adv(17); check("t3_open_cycle20", st, 2);      // tick 27, timer 19
    check("t3_no_timeout_yet", tmo, 0);
    adv(1);  check("t3_close", st, 4);             // tick 28
    check("t3_timeout_pulse", tmo, 1);
    check("t3_bo_dropped", bo, 0);
    adv(1);  check("t3_timeout_one_cycle", tmo, 0);
    adv(1);  pass = 1'b1;                            // tick 30
    adv(7);  check("t3_tailgate_pulse", tg, 1);    // tick 37
    check("t3_tailgate_bo", bo, 0);
    check("t3_tailgate_state", st, 4);
    adv(1);  check("t3_tailgate_one_cycle", tg, 0);
    adv(2);  pass = 1'b0;                            // tick 40
    adv(10); arrive = 1'b1;                          // tick 50
    adv(27); check("t3_close_last", st, 4);        // tick 77
    adv(1);  check("t3_idle", st, 0);              // tick 78
    adv(2);  check("t3_no_stale_arrival", st, 0);  // tick 80
    arrive = 1'b0;
    check("t3_timeout_count", tmo_cnt - s_tmo, 1);
    check("t3_tailgate_count", tg_cnt - s_tg, 1);
    check("t3_no_event", ev_cnt - s_ev, 0);
    adv(10);

    // 3-cycle glitch rejected, 4-cycle pulse accepted (then denied).
    vac = 1'b0;
    arrive = 1'b1;
    adv(3);  arrive = 1'b0;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      adv(1);
      if (st != 3'd0) bad++;
    end
    check("t4_glitch_ignored", bad, 0);
    arrive = 1'b1;
    adv(4);  arrive = 1'b0;
    adv(3);  check("t4_pulse_accepted", st, 1);    // tick 7
    adv(1);  check("t4_denied", st, 5);
    adv(3);  check("t4_idle", st, 0);              // tick 11

    // Reversal out of PASSING: no event.
    s_ev = ev_cnt;
    arrive = 1'b1; vac = 1'b1;
    adv(10); arrive = 1'b0; pass = 1'b1;
    adv(7);  check("t5_passing", st, 3);           // tick 17
    adv(3);  arrive = 1'b1;                          // tick 20
    adv(10); pass = 1'b0;                            // tick 30
    adv(7);  check("t5_close", st, 4);             // tick 37
    check("t5_no_event_pulse", ev_n, 1);
    adv(3);  arrive = 1'b0;                          // tick 40
    adv(47); check("t5_idle", st, 0);              // tick 87
    check("t5_no_event", ev_cnt - s_ev, 0);

    // Reset while PASSING.
    s_ev = ev_cnt;
    arrive = 1'b1;
    adv(10); arrive = 1'b0; pass = 1'b1;
    adv(7);  check("t6_passing", st, 3);
    check("t6_bo_open", bo, 1);
    adv(3);  reset = 1'b1;
    adv(1);  check("t6_reset_idle", st, 0);
    check("t6_reset_bo", bo, 0);
    check("t6_reset_event_n", ev_n, 1);
    pass = 1'b0;
    adv(1);  reset = 1'b0;
    adv(10); check("t6_stays_idle", st, 0);
    check("t6_no_event", ev_cnt - s_ev, 0);

    // Exit gate ignores vacancy, reports the card class.
    s_xev = xev_cnt;
    x_arrive = 1'b1; x_uni_card = 1'b1;
    adv(8);  check("t7_open", x_st, 2);
    check("t7_bo_open", x_bo, 1);
    adv(2);  x_arrive = 1'b0; x_pass = 1'b1;
    adv(7);  check("t7_passing", x_st, 3);         // tick 17
    adv(8);  x_pass = 1'b0;                          // tick 25
    adv(7);  check("t7_close", x_st, 4);           // tick 32
    check("t7_event_low", x_ev_n, 0);
    check("t7_event_class", x_is_uni, 1);
    adv(1);  check("t7_event_one_cycle", x_ev_n, 1);
    check("t7_class_held", x_is_uni, 1);
    check("t7_event_count", xev_cnt - s_xev, 1);
    adv(55); check("t7_idle", x_st, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/parking_gate_ctrl.md
PARKING_GATE_CTRL -- requirements
Module: parking_gate_ctrl

Interface
REQ-001 SHALL have parameter IS_EXIT, default 0; 1 = exit gate, which ignores vacancy.
REQ-002 SHALL have parameter DEBOUNCE, default 4; sensor stable cycles required before a level is accepted.
REQ-003 SHALL have parameter OPEN_TIMEOUT, default 1000; cycles the barrier waits open for passage.
REQ-004 SHALL have parameter CLOSE_CYCLES, default 50; cycles the barrier takes to lower.
REQ-005 SHALL have port clk, input, 1 bit: single clock; one clock, all logic on rising edge.
REQ-006 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-007 SHALL have port arrive_loop, input, 1 bit: raw approach-loop sensor, 1 = vehicle present.
REQ-008 SHALL have port pass_loop, input, 1 bit: raw loop under the barrier, 1 = vehicle present.
REQ-009 SHALL have port uni_card, input, 1 bit: university permit read at arrival.
REQ-010 SHALL have port uni_is_vacated_space, input, 1 bit: university space available, from the occupancy core.
REQ-011 SHALL have port is_vacated_space, input, 1 bit: other space available, from the occupancy core.
REQ-012 SHALL have port barrier_open, output, 1 bit: barrier raise command.
REQ-013 SHALL have port car_event_n, output, 1 bit: active-low one-cycle pulse per completed passage; feeds car_entered/car_exited of the occupancy core.
REQ-014 SHALL have port is_uni_event, output, 1 bit: class of the last event; feeds is_uni_car_entered/exited.
REQ-015 SHALL have port deny, output, 1 bit: one-cycle pulse when entry is refused.
REQ-016 SHALL have port timeout_err, output, 1 bit: one-cycle pulse when the open window expires without passage.
REQ-017 SHALL have port tailgate_err, output, 1 bit: one-cycle pulse when pass_loop rises in CLOSE.
REQ-018 SHALL have port state, output, 3 bits: current FSM state encoding.

Function
REQ-019 Each raw sensor SHALL be 2-flop synchronised, then debounced: the filtered level changes only after DEBOUNCE consecutive equal samples; the counter restarts on any mismatch.
REQ-020 FSM states SHALL be IDLE=0, CHECK=1, OPEN=2, PASSING=3, CLOSE=4, WAIT_LEAVE=5; unused codes go to IDLE next cycle.
REQ-021 IDLE: on the rising edge of filtered arrive, SHALL latch uni_card into uni_lat and go to CHECK.
REQ-022 CHECK lasts exactly 1 cycle. The gate is granted if IS_EXIT=1, else if uni_lat ? uni_is_vacated_space : is_vacated_space. Grant goes to OPEN; otherwise deny=1 for that cycle and the FSM goes to WAIT_LEAVE.
REQ-023 WAIT_LEAVE: SHALL go to IDLE when filtered arrive is 0.
REQ-024 OPEN: barrier_open=1 and the 16-bit timer increments each cycle from 0. Filtered pass=1 goes to PASSING. Otherwise, when the timer reaches OPEN_TIMEOUT-1, timeout_err=1 for one cycle and the FSM goes to CLOSE.
REQ-025 PASSING: barrier_open=1. On the falling edge of filtered pass, the FSM SHALL drive car_event_n=0 for exactly one cycle, update is_uni_event<=uni_lat in that same cycle, and go to CLOSE. The event count is exactly 1 per passage.
REQ-026 Reversing out of PASSING: if pass falls while filtered arrive=1 and the vehicle re-entered arrive after pass rose, no event SHALL be emitted. In that case the FSM goes to CLOSE.
REQ-027 CLOSE: barrier_open=0 and the timer counts CLOSE_CYCLES cycles, then IDLE. A rising filtered pass in CLOSE pulses tailgate_err and does not reopen. An arrival during CLOSE is not accepted; it needs a fresh rising edge in IDLE.
REQ-028 is_uni_event SHALL hold its value between events. car_event_n SHALL be 1 at all other times.
REQ-029 Every pulse output SHALL be registered and high for exactly one cycle per cause. Simultaneous causes are impossible by construction, because each belongs to a distinct state.
REQ-030 Vacancy inputs SHALL be sampled only in CHECK; changes elsewhere are ignored.
REQ-031 Timer SHALL saturate and never wrap; OPEN_TIMEOUT and CLOSE_CYCLES SHALL each be at most 65535.

Reset
REQ-032 With reset=1 at a clock edge, the block SHALL enter IDLE with these values:
- barrier_open=0, car_event_n=1, is_uni_event=0, deny=0, timeout_err=0, tailgate_err=0;
- timer=0, uni_lat=0;
- debounce counters=0, filtered levels=0, synchronisers=0.
REQ-033 Reset mid-operation (e.g. in PASSING) SHALL emit no event and close the barrier on the next cycle.

Structure
REQ-034 A shared package SHALL hold the FSM state encoding and the default constants DEBOUNCE, OPEN_TIMEOUT and CLOSE_CYCLES.
REQ-035 The synchroniser plus debounce SHALL be sub-module gate_debounce, parameterised by DEBOUNCE and instantiated twice.
REQ-036 Target size SHALL be 150-300 RTL lines.

Verification
REQ-037 Entry, other class, is_vacated_space=1: arrive 10 cycles, pass 20 cycles, then clear -> barrier_open high from CHECK+1 until pass falls; exactly one car_event_n low with is_uni_event=0; IDLE after 50 CLOSE cycles.
REQ-038 Entry, uni_card=1, uni_is_vacated_space=0 -> deny pulse of 1 cycle, barrier_open stays 0, no event, WAIT_LEAVE until arrive clears.
REQ-039 OPEN_TIMEOUT=20, no pass -> timeout_err at OPEN cycle 20, barrier drops, no event.
REQ-040 Glitches on arrive of 3 cycles with DEBOUNCE=4 -> FSM stays in IDLE; a 4-cycle pulse is accepted.
REQ-041 Pass rises during CLOSE -> tailgate_err pulse, barrier stays 0; reset asserted in PASSING -> IDLE, car_event_n stays 1.
REQ-042 IS_EXIT=1 with both vacancy flags 0 -> gate still opens and emits one event with is_uni_event=uni_card.
